// File: rtl/bus_arbiter_if.sv
// Shared-bus bundle between producers and the arbiter: requests, locks, flattened source data and the registered bus.
// The contention flag exists only when BUS_CONTENTION_EN is defined.
interface bus_arbiter_if #(
  parameter int WIDTH   = 16,
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0]       req;
  logic [NUM_SRC-1:0]       lock;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [WIDTH-1:0]         out;
  logic                     out_valid;
  logic [NUM_SRC-1:0]       grant;
  logic                     busy;
`ifdef BUS_CONTENTION_EN
  logic                     contention;

  modport master (output req, lock, src_data, input out, out_valid, grant, busy, contention);
  modport slave  (input req, lock, src_data, output out, out_valid, grant, busy, contention);
`else
  modport master (output req, lock, src_data, input out, out_valid, grant, busy);
  modport slave  (input req, lock, src_data, output out, out_valid, grant, busy);
`endif
endinterface

// File: rtl/bus_arbiter.sv
// Registered N-source bus arbiter (fixed-priority or round-robin) with bus locking and lock time-out; grant/out
// appear one edge after req is sampled. BUS_CONTENTION_EN adds a sticky contention flag and counter.
module bus_arbiter #(
  parameter int WIDTH    = 16,
  parameter int NUM_SRC  = 4,
  parameter int RR_MODE  = 0,
  parameter int MAX_LOCK = 0
) (
  input logic          clk,
  input logic          rst,
  bus_arbiter_if.slave bus
);
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = (MAX_LOCK > 0) ? $clog2(MAX_LOCK + 1) : 1;
  localparam logic [IW:0] NS = (IW+1)'(NUM_SRC);

  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [IW-1:0]      r_ptr, w_ptr_nxt;
  logic [CW-1:0]      r_lock_cnt, w_lock_cnt_nxt;
  logic [NUM_SRC-1:0] r_grant, w_grant_nxt;
  logic [WIDTH-1:0]   r_out, w_out_nxt;
  logic               r_out_valid;
  logic               r_busy;

  logic                 w_hold_req, w_timeout, w_hold;
  logic [NUM_SRC-1:0]   w_excl, w_avail, w_cand, w_rot, w_win_oh;
  logic [2*NUM_SRC-1:0] w_dbl;
  logic [IW-1:0]        w_base, w_off, w_win_idx;
  logic [IW:0]          w_sum, w_inc;
  logic                 w_win_found;

  // The grantee keeps the bus while it holds req+lock, unless it has used up its lock budget.
  assign w_hold_req = (r_state == LOCKED) && (|(bus.req & bus.lock & r_grant));
  assign w_timeout  = (MAX_LOCK > 0) && w_hold_req && (r_lock_cnt >= CW'(MAX_LOCK));
  assign w_hold     = w_hold_req && !w_timeout;

  assign w_excl  = w_timeout ? r_grant : '0;
  assign w_avail = bus.req & ~w_excl;
  assign w_cand  = (|w_avail) ? w_avail : bus.req;
  assign w_base  = (RR_MODE != 0) ? r_ptr : '0;
  assign w_dbl   = {w_cand, w_cand} >> w_base;
  assign w_rot   = w_dbl[NUM_SRC-1:0];

  always_comb begin
    w_win_found = 1'b0;
    w_off       = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_win_found = 1'b1;
        w_off       = IW'(k);
      end
    end
  end

  always_comb begin
    w_sum = {1'b0, w_base} + {1'b0, w_off};
    if (w_sum >= NS) begin
      w_sum = w_sum - NS;
    end
    w_win_idx = w_sum[IW-1:0];
  end

  assign w_win_oh = w_win_found ? (NUM_SRC'(1) << w_win_idx) : '0;
  assign w_inc    = {1'b0, w_win_idx} + (IW+1)'(1);

  always_comb begin
    w_state_nxt    = ARB;
    w_lock_cnt_nxt = '0;
    if (w_hold) begin
      w_state_nxt    = LOCKED;
      w_lock_cnt_nxt = (r_lock_cnt == '1) ? r_lock_cnt : r_lock_cnt + CW'(1);
    end else if (|(w_win_oh & bus.lock)) begin
      w_state_nxt    = LOCKED;
      w_lock_cnt_nxt = CW'(1);
    end
  end

  always_comb begin
    w_grant_nxt = w_hold ? r_grant : w_win_oh;
    w_ptr_nxt   = r_ptr;
    if (!w_hold && w_win_found) begin
      w_ptr_nxt = (w_inc == NS) ? '0 : w_inc[IW-1:0];
    end
    // Data follows the grantee every cycle, including while locked.
    w_out_nxt = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (w_grant_nxt[k]) begin
        w_out_nxt = bus.src_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB;
      r_ptr       <= '0;
      r_lock_cnt  <= '0;
      r_grant     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_lock_cnt  <= w_lock_cnt_nxt;
      r_grant     <= w_grant_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= |w_grant_nxt;
      r_busy      <= (w_state_nxt == LOCKED);
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;
  assign bus.grant     = r_grant;
  assign bus.busy      = r_busy;

`ifdef BUS_CONTENTION_EN
  logic       r_contention;
  logic [7:0] contention_cnt;
  logic       w_cont_evt;

  // x & (x-1) is non-zero exactly when two or more request bits are set.
  assign w_cont_evt = (r_state == LOCKED) ? (|(bus.req & ~r_grant))
                                          : (|(bus.req & (bus.req - NUM_SRC'(1))));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_contention   <= 1'b0;
      contention_cnt <= '0;
    end else if (w_cont_evt) begin
      r_contention <= 1'b1;
      if (contention_cnt != 8'hFF) begin
        contention_cnt <= contention_cnt + 8'd1;
      end
    end
  end

  assign bus.contention = r_contention;
`endif
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: three instances (fixed, round-robin, fixed with MAX_LOCK=3) share one stimulus stream and
// are checked against directed expectations and a queue-free integer reference model.
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_arbiter_if #(.WIDTH(16), .NUM_SRC(4)) if_fix ();
  bus_arbiter_if #(.WIDTH(16), .NUM_SRC(4)) if_rr ();
  bus_arbiter_if #(.WIDTH(16), .NUM_SRC(4)) if_to ();

  bus_arbiter #(.WIDTH(16), .NUM_SRC(4), .RR_MODE(0), .MAX_LOCK(0)) u_fix (.clk(clk), .rst(rst), .bus(if_fix.slave));
  bus_arbiter #(.WIDTH(16), .NUM_SRC(4), .RR_MODE(1), .MAX_LOCK(0)) u_rr  (.clk(clk), .rst(rst), .bus(if_rr.slave));
  bus_arbiter #(.WIDTH(16), .NUM_SRC(4), .RR_MODE(0), .MAX_LOCK(3)) u_to  (.clk(clk), .rst(rst), .bus(if_to.slave));

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0]  cur_req  = '0;
  logic [3:0]  cur_lock = '0;
  logic [63:0] cur_data = '0;

  // Reference model: current owner, whether it holds a lock, how long, and the round-robin start point.
  int         m_g   [3];
  bit         m_lk  [3];
  int         m_ptr [3];
  int         m_cnt [3];
  logic [3:0]  e_grant [3];
  logic [15:0] e_out   [3];
  logic        e_valid [3];
  logic        e_busy  [3];

  task automatic model_reset(input int id);
    m_g[id] = -1; m_lk[id] = 1'b0; m_ptr[id] = 0; m_cnt[id] = 0;
    e_grant[id] = '0; e_out[id] = '0; e_valid[id] = 1'b0; e_busy[id] = 1'b0;
  endtask

  task automatic model_step(input int id, input logic [3:0] rq, input logic [3:0] lk, input logic [63:0] d);
    int  rr = (id == 1) ? 1 : 0;
    int  ml = (id == 2) ? 3 : 0;
    int  w  = -1;
    bit  holding = 1'b0;
    bit  expired;
    logic [3:0] cand;
    if (m_lk[id]) holding = rq[m_g[id]] && lk[m_g[id]];
    expired = holding && (ml > 0) && (m_cnt[id] >= ml);
    if (holding && !expired) begin
      w = m_g[id];
      m_cnt[id] = m_cnt[id] + 1;
    end else begin
      cand = rq;
      if (expired && ((rq & ~(4'b0001 << m_g[id])) != 4'b0000)) cand[m_g[id]] = 1'b0;
      for (int s = 0; s < 4; s++) begin
        int i = rr ? (m_ptr[id] + s) % 4 : s;
        if (w < 0 && cand[i]) w = i;
      end
      m_lk[id] = 1'b0; m_cnt[id] = 0; m_g[id] = w;
      if (w >= 0) begin
        m_ptr[id] = (w + 1) % 4;
        if (lk[w]) begin m_lk[id] = 1'b1; m_cnt[id] = 1; end
      end
    end
    e_grant[id] = (w >= 0) ? (4'b0001 << w) : 4'b0000;
    e_out[id]   = (w >= 0) ? d[w*16 +: 16] : 16'h0000;
    e_valid[id] = (w >= 0);
    e_busy[id]  = m_lk[id];
  endtask

  task automatic drive(input logic [3:0] rq, input logic [3:0] lk, input logic [63:0] d);
    cur_req = rq; cur_lock = lk; cur_data = d;
    if_fix.req = rq; if_fix.lock = lk; if_fix.src_data = d;
    if_rr.req  = rq; if_rr.lock  = lk; if_rr.src_data  = d;
    if_to.req  = rq; if_to.lock  = lk; if_to.src_data  = d;
  endtask

  task automatic step();
    @(posedge clk);
    for (int id = 0; id < 3; id++) begin
      if (rst) model_reset(id);
      else model_step(id, cur_req, cur_lock, cur_data);
    end
    #1;
  endtask

  task automatic read_dut(input int id, output logic [3:0] g, output logic [15:0] o, output logic v, output logic b);
    case (id)
      0:       begin g = if_fix.grant; o = if_fix.out; v = if_fix.out_valid; b = if_fix.busy; end
      1:       begin g = if_rr.grant;  o = if_rr.out;  v = if_rr.out_valid;  b = if_rr.busy;  end
      default: begin g = if_to.grant;  o = if_to.out;  v = if_to.out_valid;  b = if_to.busy;  end
    endcase
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 64'h0);
    step();
    rst = 1'b0;
  endtask

  function automatic logic [63:0] rnd_data();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    logic [3:0] g; logic [15:0] o; logic v, b;
    rst = 1'b1;
    drive(4'b1111, 4'b1111, rnd_data());
    step();
    step();
    for (int id = 0; id < 3; id++) begin
      read_dut(id, g, o, v, b);
      n_tests++;
      if (g !== 4'b0000 || o !== 16'h0000 || v !== 1'b0 || b !== 1'b0) begin
        n_fail++;
        $display("FAIL reset inst=%0d got g=%b o=%h v=%b b=%b, want all zero", id, g, o, v, b);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_fixed_priority();
    apply_reset();
    drive(4'b0110, 4'b0000, {16'h1234, 16'h5555, 16'hAAAA, 16'h9999});
    step();
    n_tests++;
    if (if_fix.grant !== 4'b0010 || if_fix.out !== 16'hAAAA || if_fix.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fixed_priority got g=%b o=%h v=%b, want g=0010 o=aaaa v=1", if_fix.grant, if_fix.out, if_fix.out_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    drive(4'b1111, 4'b0000, rnd_data());
    for (int c = 0; c < 5; c++) begin
      step();
      n_tests++;
      if (if_rr.grant !== exp_seq[c] || if_rr.out !== cur_data[exp_seq[c] == 4'b0001 ? 0 : (exp_seq[c] == 4'b0010 ? 16 : (exp_seq[c] == 4'b0100 ? 32 : 48)) +: 16]) begin
        n_fail++;
        $display("FAIL round_robin step=%0d got g=%b o=%h, want g=%b", c, if_rr.grant, if_rr.out, exp_seq[c]);
      end
    end
  endtask

  task automatic test_lock();
    apply_reset();
    drive(4'b0100, 4'b0100, rnd_data());
    step();
    n_tests++;
    if (if_fix.grant !== 4'b0100 || if_fix.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_take got g=%b b=%b, want g=0100 b=1", if_fix.grant, if_fix.busy);
    end
    for (int c = 0; c < 5; c++) begin
      drive(4'b1111, 4'b0100, rnd_data());
      step();
      n_tests++;
      if (if_fix.grant !== 4'b0100 || if_fix.busy !== 1'b1 || if_fix.out !== cur_data[47:32]) begin
        n_fail++;
        $display("FAIL lock_hold c=%0d got g=%b b=%b o=%h, want g=0100 b=1 o=%h", c, if_fix.grant, if_fix.busy, if_fix.out, cur_data[47:32]);
      end
    end
    drive(4'b1111, 4'b0000, rnd_data());
    step();
    n_tests++;
    if (if_fix.grant !== 4'b0001 || if_fix.busy !== 1'b0 || if_fix.out !== cur_data[15:0]) begin
      n_fail++;
      $display("FAIL lock_release got g=%b b=%b o=%h, want g=0001 b=0 o=%h", if_fix.grant, if_fix.busy, if_fix.out, cur_data[15:0]);
    end
    drive(4'b0000, 4'b0000, 64'h0);
    step();
    drive(4'b0011, 4'b0010, rnd_data());
    step();
    n_tests++;
    if (if_fix.grant !== 4'b0001 || if_fix.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL foreign_lock got g=%b b=%b, want g=0001 b=0", if_fix.grant, if_fix.busy);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] exp_g [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001};
    logic       exp_b [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    apply_reset();
    drive(4'b0011, 4'b0001, rnd_data());
    for (int c = 0; c < 6; c++) begin
      step();
      n_tests++;
      if (if_to.grant !== exp_g[c] || if_to.busy !== exp_b[c]) begin
        n_fail++;
        $display("FAIL timeout c=%0d got g=%b b=%b, want g=%b b=%b", c, if_to.grant, if_to.busy, exp_g[c], exp_b[c]);
      end
    end
  endtask

  task automatic test_reset_mid_lock();
    apply_reset();
    drive(4'b0001, 4'b0001, rnd_data());
    step();
    rst = 1'b1;
    step();
    n_tests++;
    if (if_fix.grant !== 4'b0000 || if_fix.busy !== 1'b0 || if_fix.out_valid !== 1'b0 || if_fix.out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_mid_lock got g=%b b=%b v=%b o=%h, want all zero", if_fix.grant, if_fix.busy, if_fix.out_valid, if_fix.out);
    end
    rst = 1'b0;
  endtask

  task automatic test_contention();
    apply_reset();
    drive(4'b0011, 4'b0000, rnd_data());
    step();
    n_tests++;
    if (if_fix.grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL contention_grant got g=%b, want 0001", if_fix.grant);
    end
    drive(4'b0000, 4'b0000, rnd_data());
    step();
    n_tests++;
    if (if_fix.grant !== 4'b0000 || if_fix.out_valid !== 1'b0 || if_fix.out !== 16'h0000) begin
      n_fail++;
      $display("FAIL idle got g=%b v=%b o=%h, want zero", if_fix.grant, if_fix.out_valid, if_fix.out);
    end
`ifdef BUS_CONTENTION_EN
    n_tests++;
    if (if_fix.contention !== 1'b1) begin
      n_fail++;
      $display("FAIL contention_sticky got %b, want 1", if_fix.contention);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if (if_fix.contention !== 1'b0) begin
      n_fail++;
      $display("FAIL contention_clear got %b, want 0", if_fix.contention);
    end
`endif
  endtask

  task automatic test_random();
    logic [3:0] g; logic [15:0] o; logic v, b;
    logic [3:0] rq = 4'b0000;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      drive(rq, 4'($urandom) | 4'($urandom), rnd_data());
      step();
      for (int id = 0; id < 3; id++) begin
        read_dut(id, g, o, v, b);
        n_tests++;
        if (g !== e_grant[id] || o !== e_out[id] || v !== e_valid[id] || b !== e_busy[id]) begin
          n_fail++;
          $display("FAIL random c=%0d inst=%0d got g=%b o=%h v=%b b=%b, want g=%b o=%h v=%b b=%b",
                   c, id, g, o, v, b, e_grant[id], e_out[id], e_valid[id], e_busy[id]);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    drive(4'b0000, 4'b0000, 64'h0);
    for (int id = 0; id < 3; id++) model_reset(id);
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_lock();
    test_timeout();
    test_reset_mid_lock();
    test_contention();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
